// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the binary-to-BCD display feeder
//
// Purpose : digit codes, decimal range limits, FSM state type and the
//           double-dabble digit correction used by seg7_bin2bcd and
//           seg7_dabble_step.
// Ports   : none (package)

package seg7_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t DIG_BLANK  = 4'hA;
   localparam digit_t DIG_MINUS  = 4'hF;
   localparam int     DIGITS_DEF = 8;

   // Largest magnitudes that fit: all digits for positives, one digit
   // fewer for negatives because the minus sign takes a position.
   localparam logic [63:0] POS_MAX = 64'd99_999_999;
   localparam logic [63:0] NEG_MAX = 64'd9_999_999;

   typedef enum logic [1:0] {IDLE, PREP, SHIFT, FMT} b2b_state_t;

   // Add-3 correction applied to a BCD digit before each left shift.
   function automatic digit_t dabble_fix(input digit_t d);
      return (d >= 4'd5) ? digit_t'(d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/seg7_dabble_step.sv
// rtl/seg7_dabble_step.sv - one combinational double-dabble iteration
//
// Purpose : add-3 correction on every BCD digit, then shift {bcd, bin}
//           left by one bit.
// Ports   : bcd_i / bcd_o  BCD accumulator before / after the step
//           bin_i / bin_o  binary shift register before / after the step

module seg7_dabble_step #(
   parameter int NDIG  = 9,
   parameter int BIN_W = 32
) (
   input  logic [4*NDIG-1:0] bcd_i,
   input  logic [BIN_W-1:0]  bin_i,
   output logic [4*NDIG-1:0] bcd_o,
   output logic [BIN_W-1:0]  bin_o
);

   import seg7_pkg::*;

   logic [4*NDIG-1:0] fixed;

   always_comb begin
      fixed = '0;
      for (int i = 0; i < NDIG; i++) begin
         fixed[4*i +: 4] = dabble_fix(bcd_i[4*i +: 4]);
      end
   end

   // Top bit of the corrected accumulator falls off; the accumulator is
   // sized one digit wider than the display so nothing meaningful is lost.
   assign {bcd_o, bin_o} = {fixed, bin_i} << 1;

endmodule

// File: rtl/seg7_bin2bcd.sv
// rtl/seg7_bin2bcd.sv - sequential signed binary to packed 7-segment digit codes
//
// Purpose : converts a two's-complement value into DIGITS packed 4-bit
//           digit codes (0-9 BCD, A blank, F minus) with an iterative
//           double-dabble engine; result held until the next conversion.
// Ports   : clk_i    system clock
//           rst_n    synchronous active-low reset
//           valid_i  conversion request, accepted when ready_o is high
//           data_i   signed input value, captured on accept
//           ready_o  high in IDLE only
//           done_o   one-cycle pulse when num_o/ovf_o update
//           num_o    packed digit codes, digit 0 in bits [3:0]
//           ovf_o    last conversion was out of displayable range
// Options : SEG7_LEAD_ZERO_BLANK_EN blanks leading zeros and floats the
//           minus sign next to the most significant digit.

module seg7_bin2bcd
   import seg7_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic [DATA_W-1:0]     data_i,
   output logic                  ready_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   num_o,
   output logic                  ovf_o
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int NUM_W = 4*DIGITS;
   localparam int BCD_W = NUM_W + 4;

   b2b_state_t        state, next_state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] mag_q;
   logic [BCD_W-1:0]  bcd_q;
   logic              neg_q;
   logic              ovf_q;

   logic [DATA_W-1:0] mag_nxt;
   logic [BCD_W-1:0]  bcd_nxt;
   logic              neg_w;
   logic [DATA_W-1:0] mag_w;
   logic [63:0]       mag_ext;
   logic              ovf_w;
   logic              ovf_fmt;
   logic [NUM_W-1:0]  fmt_num;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (valid_i) next_state = PREP;
         PREP:    next_state = SHIFT;
         SHIFT:   if (cnt == CNT_W'(DATA_W-1)) next_state = FMT;
         FMT:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ready_o = (state == IDLE);
   end

   // ---------------- PREP: sign, magnitude, range ----------------
   // Negating the most negative value wraps back to itself, which read as
   // unsigned is exactly its magnitude.
   assign neg_w   = data_q[DATA_W-1];
   assign mag_w   = neg_w ? (~data_q + 1'b1) : data_q;
   assign mag_ext = 64'(mag_w);
   assign ovf_w   = neg_w ? (mag_ext > NEG_MAX) : (mag_ext > POS_MAX);

   seg7_dabble_step #(
      .NDIG  (DIGITS + 1),
      .BIN_W (DATA_W)
   ) u_step (
      .bcd_i (bcd_q),
      .bin_i (mag_q),
      .bcd_o (bcd_nxt),
      .bin_o (mag_nxt)
   );

   // ---------------- FMT: result formatting ----------------
   // The spare top digit can only be nonzero if the range check already
   // flagged overflow; folding it in keeps odd parameterisations honest.
   assign ovf_fmt = ovf_q | (|bcd_q[BCD_W-1 -: 4]);

`ifdef SEG7_LEAD_ZERO_BLANK_EN
   logic lead;
   logic placed;
`endif

   always_comb begin
      fmt_num = bcd_q[NUM_W-1:0];
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      lead   = 1'b1;
      placed = 1'b0;
`endif
      if (ovf_fmt) begin
         fmt_num = {DIGITS{DIG_MINUS}};
      end else begin
`ifdef SEG7_LEAD_ZERO_BLANK_EN
         // Blank zeros from the top down; digit 0 is always shown.
         for (int i = DIGITS-1; i >= 1; i--) begin
            if (fmt_num[4*i +: 4] != 4'd0) lead = 1'b0;
            if (lead) fmt_num[4*i +: 4] = DIG_BLANK;
         end
         // Blanks are contiguous from the top, so the lowest blank sits
         // right above the most significant shown digit.
         if (neg_q) begin
            for (int i = 1; i < DIGITS; i++) begin
               if (!placed && fmt_num[4*i +: 4] == DIG_BLANK) begin
                  fmt_num[4*i +: 4] = DIG_MINUS;
                  placed            = 1'b1;
               end
            end
         end
`else
         if (neg_q) fmt_num[NUM_W-1 -: 4] = DIG_MINUS;
`endif
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         cnt    <= '0;
         data_q <= '0;
         mag_q  <= '0;
         bcd_q  <= '0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
         done_o <= 1'b0;
         ovf_o  <= 1'b0;
         num_o  <= {DIGITS{DIG_BLANK}};
      end else begin
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (valid_i) data_q <= data_i;
            end
            PREP: begin
               neg_q <= neg_w;
               ovf_q <= ovf_w;
               mag_q <= mag_w;
               bcd_q <= '0;
               cnt   <= '0;
            end
            SHIFT: begin
               bcd_q <= bcd_nxt;
               mag_q <= mag_nxt;
               cnt   <= cnt + 1'b1;
            end
            FMT: begin
               num_o  <= fmt_num;
               ovf_o  <= ovf_fmt;
               done_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_bin2bcd.sv
// tb/tb_seg7_bin2bcd.sv - self-checking bench for seg7_bin2bcd

module tb_seg7_bin2bcd;

   logic        clk_i   = 1'b0;
   logic        rst_n   = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] data_i  = '0;
   logic        ready_o;
   logic        done_o;
   logic [31:0] num_o;
   logic        ovf_o;

   int vectors     = 0;
   int miscompares = 0;

   seg7_bin2bcd #(
      .DATA_W (32),
      .DIGITS (8)
   ) dut (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .valid_i (valid_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .done_o  (done_o),
      .num_o   (num_o),
      .ovf_o   (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits by plain division on a 64-bit magnitude.
   function automatic void model(input logic [31:0] v, output logic [31:0] num, output logic ovf);
      longint s, m;
      int     nd;
      s   = longint'($signed(v));
      m   = (s < 0) ? -s : s;
      ovf = (s < 0) ? (m > 64'd9_999_999) : (m > 64'd99_999_999);
      num = 32'hFFFF_FFFF;
      if (ovf) return;
      nd = 1;
      for (int i = 0; i < 8; i++) begin
         num[4*i +: 4] = 4'(m % 10);
         if (m % 10 != 0) nd = i + 1;
         m = m / 10;
      end
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      for (int i = nd; i < 8; i++) num[4*i +: 4] = 4'hA;
      if (s < 0) num[4*nd +: 4] = 4'hF;
`else
      if (s < 0) num[31:28] = 4'hF;
`endif
   endfunction

   // Called at a negedge; returns the number of clock edges until done_o.
   task automatic wait_done(output int n);
      n = 0;
      while (done_o !== 1'b1 && n < 100) begin
         @(negedge clk_i);
         n++;
      end
   endtask

   task automatic convert(input logic [31:0] v, input logic [31:0] en, input logic eo, input string tag);
      int n;
      check_eq({tag, " ready"}, 32'(ready_o), 32'd1);
      valid_i = 1'b1;
      data_i  = v;
      @(negedge clk_i);
      valid_i = 1'b0;
      wait_done(n);
      check_eq({tag, " latency"}, 32'(n), 32'd34);
      check_eq({tag, " num"}, num_o, en);
      check_eq({tag, " ovf"}, 32'(ovf_o), 32'(eo));
      check_eq({tag, " ready_in_done"}, 32'(ready_o), 32'd1);
      @(negedge clk_i);
      check_eq({tag, " done_one_cycle"}, 32'(done_o), 32'd0);
   endtask

   localparam int ND = 8;
   logic [31:0] dir_val [ND];
   logic [31:0] dir_num [ND];
   logic        dir_ovf [ND];

   initial begin
      int          n;
      int          seen;
      logic [31:0] v, en;
      logic        eo;

      dir_val = '{32'd12345678, 32'd0, 32'hFFFF_FFD6, 32'd99_999_999,
                  32'd100_000_000, 32'hFF67_6981, 32'hFF67_6980, 32'h8000_0000};
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      dir_num = '{32'h12345678, 32'hAAAAAAA0, 32'hAAAAAF42, 32'h99999999,
                  32'hFFFFFFFF, 32'hF9999999, 32'hFFFFFFFF, 32'hFFFFFFFF};
`else
      dir_num = '{32'h12345678, 32'h00000000, 32'hF0000042, 32'h99999999,
                  32'hFFFFFFFF, 32'hF9999999, 32'hFFFFFFFF, 32'hFFFFFFFF};
`endif
      dir_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      // reset state
      repeat (2) @(negedge clk_i);
      check_eq("reset ready", 32'(ready_o), 32'd1);
      check_eq("reset done", 32'(done_o), 32'd0);
      check_eq("reset ovf", 32'(ovf_o), 32'd0);
      check_eq("reset num", num_o, 32'hAAAAAAAA);
      rst_n = 1'b1;
      @(negedge clk_i);

      // directed values including range limits
      for (int i = 0; i < ND; i++) begin
         convert(dir_val[i], dir_num[i], dir_ovf[i], $sformatf("dir%0d", i));
      end

      // valid held high: 7 ignored while busy, accepted in the done cycle
      valid_i = 1'b1;
      data_i  = 32'd5;
      @(negedge clk_i);
      data_i  = 32'd7;
      repeat (10) @(negedge clk_i);
      check_eq("hold busy ready", 32'(ready_o), 32'd0);
      wait_done(n);
      check_eq("hold first latency", 32'(n + 10), 32'd34);
      check_eq("hold first num", num_o, 32'h00000005);
      @(negedge clk_i);
      valid_i = 1'b0;
      check_eq("hold second accepted", 32'(ready_o), 32'd0);
      wait_done(n);
      check_eq("hold second latency", 32'(n), 32'd34);
      check_eq("hold second num", num_o, 32'h00000007);
      @(negedge clk_i);

      // reset in the middle of SHIFT, right after an overflowing result
      convert(32'd100_000_000, 32'hFFFFFFFF, 1'b1, "pre_rst");
      valid_i = 1'b1;
      data_i  = 32'd12345;
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (11) @(negedge clk_i);
      rst_n = 1'b0;
      @(negedge clk_i);
      rst_n = 1'b1;
      check_eq("midrst num", num_o, 32'hAAAAAAAA);
      check_eq("midrst ovf", 32'(ovf_o), 32'd0);
      check_eq("midrst ready", 32'(ready_o), 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_o === 1'b1) seen++;
         @(negedge clk_i);
      end
      check_eq("midrst no_done", 32'(seen), 32'd0);
      model(32'd777, en, eo);
      convert(32'd777, en, eo, "post_rst");

      // randomized values across the interesting ranges
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 2))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 100_000_010));
            default: v = 32'd0 - 32'($urandom_range(0, 10_000_010));
         endcase
         model(v, en, eo);
         convert(v, en, eo, $sformatf("rnd%0d v=%0d", k, $signed(v)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
